// File: rtl/dispatch_stage_buffer_pkg.sv
// Shared types for the ID/EX dispatch buffer: side-unit indices and the decoded-instruction payload.
package dispatch_stage_buffer_pkg;

  localparam int UNIT_MUL       = 0;
  localparam int UNIT_DIV       = 1;
  localparam int UNIT_FPU       = 2;
  localparam int NUM_EXEC_UNITS = 3;

  // 256-bit packed payload carried from decode/reg-read into EX
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] imm;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [15:0] op;
    logic [15:0] flags;
  } decoded_inst_t;

endpackage

// File: rtl/dispatch_stage_buffer_slot.sv
// One buffer entry: payload, side-unit pending mask and valid bit, with load, clear and per-unit retire.
module skid_slot
  import dispatch_stage_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(decoded_inst_t),
  parameter int NUM_UNITS  = NUM_EXEC_UNITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [NUM_UNITS-1:0]  unit_clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_UNITS-1:0]  unit_sel_in,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [NUM_UNITS-1:0]  unit_valid
);

  // load wins over clear so a retire and a refill in one cycle keep the new entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      data       <= '0;
      unit_valid <= '0;
    end else if (load) begin
      valid      <= 1'b1;
      data       <= data_in;
      unit_valid <= unit_sel_in;
    end else if (clear) begin
      valid      <= 1'b0;
      data       <= '0;
      unit_valid <= '0;
    end else begin
      unit_valid <= unit_valid & ~unit_clear;
    end
  end

endmodule

// File: rtl/dispatch_stage_buffer.sv
// ID/EX stage register: output slot plus skid slot, fanning each entry out to the side execution units.
module dispatch_stage_buffer
  import dispatch_stage_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(decoded_inst_t),
  parameter int NUM_UNITS  = NUM_EXEC_UNITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_UNITS-1:0]  unit_sel_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_UNITS-1:0]  unit_valid_out,
  input  logic [NUM_UNITS-1:0]  unit_ready_in,
  output logic [1:0]            occupancy
);

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [NUM_UNITS-1:0]  skid_units;
  logic [NUM_UNITS-1:0]  unit_done;
  logic                  in_fire, out_fire;
  logic                  out_load, out_clear, skid_load, skid_clear;
  logic [DATA_WIDTH-1:0] out_data_nxt;
  logic [NUM_UNITS-1:0]  out_sel_nxt;

  // ready_out comes straight off the skid valid flop, so ready_in never reaches it
  assign ready_out = ~skid_valid;
  assign in_fire   = valid_in & ready_out & ~flush;
  assign unit_done = ~unit_valid_out | unit_ready_in;
  assign out_fire  = valid_out & ready_in & (&unit_done);

  assign out_load     = ~flush & ((out_fire & (skid_valid | in_fire)) | (~valid_out & in_fire));
  assign out_clear    = flush | out_fire;
  assign out_data_nxt = skid_valid ? skid_data  : data_in;
  assign out_sel_nxt  = skid_valid ? skid_units : unit_sel_in;

  // skid only catches an entry when the output slot is stuck this cycle
  assign skid_load  = in_fire & valid_out & ~out_fire;
  assign skid_clear = flush | out_fire;

  skid_slot #(.DATA_WIDTH(DATA_WIDTH), .NUM_UNITS(NUM_UNITS)) u_out_slot (
    .clk         (clk),
    .reset       (reset),
    .load        (out_load),
    .clear       (out_clear),
    .unit_clear  (unit_ready_in),
    .data_in     (out_data_nxt),
    .unit_sel_in (out_sel_nxt),
    .valid       (valid_out),
    .data        (data_out),
    .unit_valid  (unit_valid_out)
  );

  skid_slot #(.DATA_WIDTH(DATA_WIDTH), .NUM_UNITS(NUM_UNITS)) u_skid_slot (
    .clk         (clk),
    .reset       (reset),
    .load        (skid_load),
    .clear       (skid_clear),
    .unit_clear  ('0),
    .data_in     (data_in),
    .unit_sel_in (unit_sel_in),
    .valid       (skid_valid),
    .data        (skid_data),
    .unit_valid  (skid_units)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= 2'd0;
    end else if (flush) begin
      occupancy <= 2'd0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_stage_buffer.sv
// Bench for dispatch_stage_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_dispatch_stage_buffer;
  import dispatch_stage_buffer_pkg::*;

  localparam int DW = $bits(decoded_inst_t);
  localparam int NU = NUM_EXEC_UNITS;

  logic          clk = 1'b0;
  logic          reset, flush, valid_in, ready_in;
  logic          ready_out, valid_out;
  logic [DW-1:0] data_in, data_out;
  logic [NU-1:0] unit_sel_in, unit_valid_out, unit_ready_in;
  logic [1:0]    occupancy;

  dispatch_stage_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .data_in        (data_in),
    .unit_sel_in    (unit_sel_in),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .data_out       (data_out),
    .unit_valid_out (unit_valid_out),
    .unit_ready_in  (unit_ready_in),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [NU-1:0] pend;
  } ent_t;

  ent_t mq[$];   // entries held by the buffer, head = output slot
  ent_t sb[$];   // accepted entries awaiting retirement, with their full unit_sel
  logic [NU-1:0] rcv;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_edge();
    bit   in_f, out_f;
    ent_t e;
    if (reset || flush) begin
      mq.delete();
      sb.delete();
      rcv = '0;
      return;
    end
    in_f  = valid_in && (mq.size() < 2);
    out_f = (mq.size() > 0) && ready_in && ((mq[0].pend & ~unit_ready_in) == '0);
    if (out_f) void'(mq.pop_front());
    else if (mq.size() > 0) begin
      e = mq[0];
      e.pend &= ~unit_ready_in;
      mq[0] = e;
    end
    if (in_f) begin
      e.data = data_in;
      e.pend = unit_sel_in;
      mq.push_back(e);
      sb.push_back(e);
    end
  endtask

  // observe the DUT's own handshakes: retire order and each unit served exactly its selected set
  task automatic score_pre_edge();
    ent_t e;
    if (reset || flush) return;
    rcv |= unit_valid_out & unit_ready_in;
    if (valid_out && ready_in && (&(~unit_valid_out | unit_ready_in))) begin
      if (sb.size() == 0) chk("retire_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("retire_order", data_out, e.data);
        chk("unit_dispatch", rcv, e.pend);
      end
      rcv = '0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_valid"}, valid_out, mq.size() > 0);
    chk({tag, "_data"}, data_out, (mq.size() > 0) ? mq[0].data : '0);
    chk({tag, "_uvalid"}, unit_valid_out, (mq.size() > 0) ? mq[0].pend : '0);
    chk({tag, "_ready"}, ready_out, mq.size() < 2);
    chk({tag, "_occ"}, occupancy, mq.size());
  endtask

  task automatic tick(input string tag);
    score_pre_edge();
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NU-1:0] sel,
                       input logic rdy, input logic [NU-1:0] urdy);
    valid_in      = v;
    data_in       = d;
    unit_sel_in   = sel;
    ready_in      = rdy;
    unit_ready_in = urdy;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    rcv = '0;
    #12;
    compare_all("reset");
    chk("reset_ready", ready_out, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // back-to-back stream with everything accepting
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, DW'(8'hA1 + k), '0, 1'b1, '0);
      tick("stream");
      chk("stream_data", data_out, DW'(8'hA1 + k));
      chk("stream_ready", ready_out, 1);
    end
    drive(1'b0, '0, '0, 1'b1, '0);
    tick("stream_drain");

    // stall fills the skid slot
    drive(1'b1, DW'(8'hB1), '0, 1'b0, '0);
    tick("skid_b1");
    drive(1'b0, '0, '0, 1'b0, '0);
    tick("skid_hold");
    drive(1'b1, DW'(8'hB2), '0, 1'b0, '0);
    tick("skid_b2");
    chk("skid_full_ready", ready_out, 0);
    chk("skid_full_occ", occupancy, 2);
    chk("skid_full_data", data_out, DW'(8'hB1));
    drive(1'b0, '0, '0, 1'b1, '0);
    tick("skid_pop1");
    chk("skid_pop1_data", data_out, DW'(8'hB2));
    tick("skid_pop2");
    chk("skid_pop2_valid", valid_out, 0);

    // split main/unit handshakes
    drive(1'b1, DW'(8'hC1), 3'b101, 1'b1, '0);
    tick("units_load");
    chk("units_n1", unit_valid_out, 3'b101);
    drive(1'b0, '0, '0, 1'b1, 3'b001);
    tick("units_n2");
    chk("units_n2_uv", unit_valid_out, 3'b100);
    chk("units_n2_valid", valid_out, 1);
    drive(1'b0, '0, '0, 1'b1, 3'b000);
    tick("units_n3");
    chk("units_n3_uv", unit_valid_out, 3'b100);
    drive(1'b0, '0, '0, 1'b1, 3'b100);
    tick("units_retire");
    chk("units_retired", valid_out, 0);

    // flush with both slots full and a unit pending
    drive(1'b1, DW'(8'hD1), 3'b010, 1'b0, '0);
    tick("flush_d1");
    drive(1'b1, DW'(8'hD2), 3'b001, 1'b0, '0);
    tick("flush_d2");
    chk("flush_pre_occ", occupancy, 2);
    flush = 1'b1;
    drive(1'b1, DW'(8'hD3), 3'b111, 1'b0, '0);
    tick("flush");
    chk("flush_valid", valid_out, 0);
    chk("flush_data", data_out, '0);
    chk("flush_ready", ready_out, 1);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    tick("flush_after");
    chk("flush_no_capture", valid_out, 0);

    // async reset in the middle of a pending unit dispatch
    drive(1'b1, DW'(8'hE1), 3'b010, 1'b1, '0);
    tick("areset_load");
    chk("areset_pre_uv", unit_valid_out, 3'b010);
    drive(1'b0, '0, '0, 1'b1, '0);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_uv", unit_valid_out, 0);
    chk("areset_valid", valid_out, 0);
    chk("areset_data", data_out, '0);
    tick("areset_hold");
    reset = 1'b0;
    drive(1'b1, DW'(8'hE2), 3'b000, 1'b1, '0);
    tick("resume");
    chk("resume_data", data_out, DW'(8'hE2));

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      flush = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 9) < 6, {8{$urandom}}, NU'($urandom), $urandom_range(0, 1) == 1,
            NU'($urandom));
      tick("rand");
    end
    flush = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, '0, '0, 1'b1, '1);
      tick("final_drain");
    end
    chk("final_empty", valid_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
